seg7_scan: RTL and testbench
============================

# seg7_scan

Four-digit seven-segment scan driver that consumes the 4-bit value produced by the nibble select mux (`muxOut`) and shows it on the board display. A write strobe and digit index capture the selected nibble into one of four digit registers. A free-running refresh counter time-multiplexes the digits onto shared segment lines. Sits directly downstream of the nibble mux and drives the board's anode and segment pins.

## Interface
- `CLK_DIV`, default 100000: clock cycles each digit stays active. Legal range is ≥ 2.
- `clk`  input  1: system clock. All logic is on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `nibbleIn`  input  4: hex value to store. Connected to the nibble mux `muxOut`.
- `wrEn`  input  1: when high, `nibbleIn` is captured into digit `wrIdx`.
- `wrIdx`  input  2: target digit for the write. 0 is the rightmost digit.
- `blankMask`  input  4: bit i high blanks digit i. Its anode stays off while that digit is scanned.
- `an`  output  4: digit enables, active-low. `an[i]` drives digit i.
- `seg`  output  7: segments, active-low, ordered {g,f,e,d,c,b,a}.
- `scanIdx`  output  2: index of the digit currently being scanned.

## Operation
- Digit store:
  - Four 4-bit registers `digit[0..3]`.
  - On a clock edge with `wrEn`=1: `digit[wrIdx] <= nibbleIn`.
  - No other path modifies them.
- Refresh counter:
  - `divCnt` counts 0..CLK_DIV-1, then wraps to 0.
  - On the edge where `divCnt == CLK_DIV-1`, `scanIdx` increments modulo 4 (sequence 0,1,2,3,0…).
- Output stage (registered):
  - `an <= blankMask[scanIdx] ? 4'b1111 : ~(4'b0001 << scanIdx)`.
  - `seg <= blankMask[scanIdx] ? 7'h7F : hex(digit[scanIdx])`.
- Hex decode, active-low {g..a}:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (all hex).
- Reset values:
  - `digit[*]`=0, `divCnt`=0, `scanIdx`=0.
  - `an`=4'b1111, `seg`=7'h7F. The display is dark during the reset cycle.
- Boundary conditions:
  - Write to the digit currently being scanned: the new value appears on `seg` one edge after the write edge.
  - Write coinciding with a `scanIdx` advance: the write lands in its register. The output stage uses the post-advance index on the next edge.
  - `scanIdx` wraps from 3 to 0 with no idle cycle.
  - `rst` asserted mid-scan: all state returns to reset values on that edge. Stored digits are lost.
  - `wrEn` while `rst`=1 is ignored.
  - `blankMask` changes take effect on the next edge. They are not synchronised to digit boundaries.

## Timing
- Write to visible: the write is captured at edge N. `seg` reflects it at edge N+1 if that digit is being scanned, otherwise at its next scan slot.
- `an`/`seg` lag `scanIdx` by exactly one cycle. `scanIdx` is a direct register output.
- Each digit is active for CLK_DIV cycles. A full frame is 4·CLK_DIV cycles.
- First release from reset: the first clock edge with `rst`=0 loads `an`=4'b1110 and `seg`=hex(digit[0]).
- No combinational path from any input to any output.

## Configuration
- Macro `SEG7_GHOST_BLANK_EN`.
- Defined:
  - On the edge where `scanIdx` advances, the output stage loads `an`=4'b1111 and `seg`=7'h7F instead of the new digit. This gives one dark cycle per digit change and suppresses ghosting.
  - Normal drive resumes on the following edge.
  - Each digit is therefore lit for CLK_DIV-1 cycles.
- Undefined: no dark cycle. The output stage switches straight to the new digit, and each digit is lit for CLK_DIV cycles.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `wrEn`=1 and `nibbleIn`=F → `an`=1111, `seg`=7F, `scanIdx`=0. All digits read 0 once scanned after release.
- Write and scan, CLK_DIV=4:
  - Stimulus: write 1,2,3,A to digits 0..3, then idle.
  - Required: `an` cycles 1110→1101→1011→0111, 4 cycles each, with `seg` 79, 24, 30, 08. `scanIdx` wraps 3→0.
- Blanking: `blankMask`=0100, digits loaded with 8 → during scanIdx=2, `an`=1111 and `seg`=7F. The other digits show 00.
- Live update: while digit 1 is being scanned, write E to index 1 → `seg` changes from its old value to 06 exactly one edge after the write edge.
- Reset mid-scan: assert `rst` at `scanIdx`=2, `divCnt`=1 → next edge `an`=1111, `scanIdx`=0. After release, digit 0 shows 40.
- Ghost blank, with `SEG7_GHOST_BLANK_EN` defined and CLK_DIV=4:
  - Exactly one cycle of `an`=1111 at each digit change, followed by 3 lit cycles.
  - With the macro undefined there are no dark cycles.

Source files
------------

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan -- four-digit seven-segment scan driver.
//
// Stores four hex nibbles written from the nibble mux and time-multiplexes
// them onto shared active-low segment lines. Each digit is driven for CLK_DIV
// clock cycles in turn: 0, 1, 2, 3, 0, ...
//
// Parameters
//   CLK_DIV    cycles each digit stays selected (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   nibbleIn   hex value to store (from muxOut)
//   wrEn       capture nibbleIn into digit wrIdx
//   wrIdx      target digit, 0 = rightmost
//   blankMask  bit i high keeps digit i dark while it is scanned
//   an         digit enables, active-low, an[i] drives digit i
//   seg        segments, active-low, {g,f,e,d,c,b,a}
//   scanIdx    digit currently being scanned (an/seg lag it by one cycle)
//
// Build option
//   SEG7_GHOST_BLANK_EN  when defined, the output stage goes dark for one
//                        cycle at every digit change to suppress ghosting.
// ---------------------------------------------------------------------------
module seg7_scan #(
  parameter int CLK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] nibbleIn,
  input  logic       wrEn,
  input  logic [1:0] wrIdx,
  input  logic [3:0] blankMask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic [1:0] scanIdx
);

  localparam int                CntW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0]   CntLast = CntW'(CLK_DIV - 1);

  logic [3:0]      digit [4];
  logic [CntW-1:0] divCnt;
  logic            scanAdvance;
  logic            dark;

  // Active-low {g,f,e,d,c,b,a} pattern for a hex value.
  function automatic logic [6:0] hexDecode(input logic [3:0] v);
    // NOTE: the default assignment ahead of the case keeps this purely
    // combinational even if an arm is ever dropped -- no latch can appear.
    hexDecode = 7'h7F;
    case (v)
      4'h0: hexDecode = 7'h40;
      4'h1: hexDecode = 7'h79;
      4'h2: hexDecode = 7'h24;
      4'h3: hexDecode = 7'h30;
      4'h4: hexDecode = 7'h19;
      4'h5: hexDecode = 7'h12;
      4'h6: hexDecode = 7'h02;
      4'h7: hexDecode = 7'h78;
      4'h8: hexDecode = 7'h00;
      4'h9: hexDecode = 7'h10;
      4'hA: hexDecode = 7'h08;
      4'hB: hexDecode = 7'h03;
      4'hC: hexDecode = 7'h46;
      4'hD: hexDecode = 7'h21;
      4'hE: hexDecode = 7'h06;
      4'hF: hexDecode = 7'h0E;
      default: hexDecode = 7'h7F;
    endcase
  endfunction

  assign scanAdvance = (divCnt == CntLast);

`ifdef SEG7_GHOST_BLANK_EN
  // The advance edge would otherwise show the outgoing digit for one more
  // cycle while the anodes are about to switch; darken it instead.
  assign dark = blankMask[scanIdx] | scanAdvance;
`else
  assign dark = blankMask[scanIdx];
`endif

  // Digit store. The registers are cleared on reset so the display reads 0
  // after any reset, including one asserted mid-scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: a memory is normally left unreset; this one is only four
      // nibbles and its cleared contents are visible behaviour.
      for (int i = 0; i < 4; i++) digit[i] <= 4'h0;
    end else if (wrEn) begin
      digit[wrIdx] <= nibbleIn;
    end
  end

  // Refresh counter and scan index.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, matching the hardware.
      divCnt  <= '0;
      scanIdx <= 2'd0;
    end else if (scanAdvance) begin
      divCnt  <= '0;
      scanIdx <= scanIdx + 2'd1;
    end else begin
      divCnt  <= divCnt + CntW'(1);
    end
  end

  // Registered output stage: driven from the pre-edge scanIdx and digit
  // contents, so an/seg trail scanIdx by one cycle and a write is visible
  // one edge after it lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else if (dark) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else begin
      an  <= ~(4'b0001 << scanIdx);
      seg <= hexDecode(digit[scanIdx]);
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan -- scoreboard bench for seg7_scan with CLK_DIV = 4.
//
// The stimulus process drives one cycle at a time on the falling edge and
// pushes the an/seg/scanIdx values expected after the following rising
// edge. A separate monitor pops one entry after every rising edge and
// compares. Expected an/scanIdx come from the position within the frame
// counted since reset release; expected seg comes from a hand-written table
// of segment codes for what each digit holds.
// ---------------------------------------------------------------------------
module tb_seg7_scan;

  localparam int P = 4;
`ifdef SEG7_GHOST_BLANK_EN
  localparam bit Ghost = 1'b1;
`else
  localparam bit Ghost = 1'b0;
`endif

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] idx;
  } expT;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] nibbleIn;
  logic       wrEn;
  logic [1:0] wrIdx;
  logic [3:0] blankMask;
  logic [3:0] an;
  logic [6:0] seg;
  logic [1:0] scanIdx;

  expT        expQ[$];
  logic [6:0] segTab [4];   // expected segment code of each stored digit
  int         k;            // edges since reset release
  int         checks = 0;
  int         errors = 0;

  seg7_scan #(.CLK_DIV(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .nibbleIn (nibbleIn),
    .wrEn     (wrEn),
    .wrIdx    (wrIdx),
    .blankMask(blankMask),
    .an       (an),
    .seg      (seg),
    .scanIdx  (scanIdx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // One clock cycle of stimulus plus the expectation for the next edge.
  task automatic step(input logic r, input logic w, input logic [1:0] wi,
                      input logic [3:0] nib, input logic [3:0] m);
    expT        e;
    int         s;
    logic [3:0] oneHot;
    @(negedge clk);
    rst = r; wrEn = w; wrIdx = wi; nibbleIn = nib; blankMask = m;
    if (r) begin
      k = 0;
      e.an = 4'b1111; e.seg = 7'h7F; e.idx = 2'd0;
    end else begin
      k++;
      s = ((k - 1) / P) % 4;          // digit scanned before this edge
      e.idx = 2'((k / P) % 4);        // digit scanned after this edge
      if (m[s] || (Ghost && ((k - 1) % P == P - 1))) begin
        e.an = 4'b1111; e.seg = 7'h7F;
      end else begin
        oneHot = 4'b0001 << s;
        e.an  = ~oneHot;
        e.seg = segTab[s];
      end
    end
    expQ.push_back(e);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) segTab[i] = 7'h40;
  endtask

  task automatic idle(input int n, input logic [3:0] m);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 4'h0, m);
  endtask

  // Monitor: one scoreboard entry per rising edge while entries exist.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("an", {3'b000, an}, {3'b000, e.an});
        check("seg", seg, e.seg);
        check("scanIdx", {5'b0, scanIdx}, {5'b0, e.idx});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] scanSeg [4];
    scanSeg[0] = 7'h79; scanSeg[1] = 7'h24; scanSeg[2] = 7'h30; scanSeg[3] = 7'h08;
    rst = 1'b1; wrEn = 1'b0; wrIdx = 2'd0; nibbleIn = 4'h0; blankMask = 4'h0; k = 0;
    for (int i = 0; i < 4; i++) segTab[i] = 7'h40;

    // Reset with writes attempted: ignored, display dark, then all zeros.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'(i), 4'hF, 4'h0);
    idle(2 * 4 * P, 4'h0);

    // Write 1,2,3,A to digits 0..3 then scan two full frames.
    doReset(1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'(i), 4'(i == 3 ? 10 : i + 1), 4'h0);
      segTab[i] = scanSeg[i];
    end
    idle(2 * 4 * P, 4'h0);

    // Blanking digit 2 with every digit holding 8.
    doReset(1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'(i), 4'h8, 4'b0100);
      segTab[i] = 7'h00;
    end
    idle(2 * 4 * P, 4'b0100);

    // Live update: E written to digit 1 while it is on the display.
    doReset(1);
    for (int i = 0; i < 4 * P; i++) begin
      if (i == 5) begin
        step(1'b0, 1'b1, 2'd1, 4'hE, 4'h0);
        segTab[1] = 7'h06;
      end else begin
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
      end
    end

    // Reset mid-scan at scanIdx=2, divCnt=1: stored 5 is lost.
    doReset(1);
    step(1'b0, 1'b1, 2'd0, 4'h5, 4'h0);
    segTab[0] = 7'h12;
    idle(2 * P + 1 - 1, 4'h0);        // edges 2..9
    step(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) segTab[i] = 7'h40;
    idle(4 * P, 4'h0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
